// File: rtl/cussen_pkg.sv
// cussen_pkg
// Shared definitions for the run emitter that consumes the 9-input sorter's
// output: vector length, multiplicity width, index width and the FSM states.
package cussen_pkg;

    localparam int N_IN   = 9;   // entries per sorted vector
    localparam int MULT_W = 4;   // run length 1..9
    localparam int IDX_W  = 4;   // index 0..9 (9 = past the end)
    localparam int W_DEF  = 8;   // default value width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cussen_run_len.sv
// cussen_run_len
// Combinational run-length finder. Counts how many consecutive entries,
// starting at vals[idx], are equal to vals[idx]. Returns 0 when idx is at or
// past the end of the vector.
// Ports:
//   vals    - captured vector, vals[0] first
//   idx     - start position of the run (0..9)
//   run_len - length of the run starting at idx (0..9)
module cussen_run_len
    import cussen_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0]      vals [N_IN],
    input  logic [IDX_W-1:0]  idx,
    output logic [MULT_W-1:0] run_len
);

    logic [W-1:0] base;
    logic         running;

    always_comb begin
        run_len = '0;
        running = 1'b1;
        base    = '0;
        if (idx < IDX_W'(N_IN)) begin
            base = vals[idx];
        end
        // Only equality matters: an unsorted vector still yields maximal
        // runs of adjacent equal entries.
        for (int j = 0; j < N_IN; j++) begin
            if (IDX_W'(j) >= idx) begin
                if (running && (vals[j] == base)) begin
                    run_len = run_len + MULT_W'(1);
                end else begin
                    running = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/cussen_run_emitter.sv
// cussen_run_emitter
// Captures a sorted 9-entry vector plus the sorter's distinct-value count,
// then streams each distinct value with its multiplicity over valid/ready,
// one run per beat. After the last beat it checks that the number of runs
// matches the claimed count and that the vector was non-decreasing.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   load            - capture strobe, honoured only in IDLE
//   in1..in9        - sorted vector, in1 smallest
//   unique_count    - sorter's claimed distinct-value count
//   busy            - high from capture until DONE exits
//   out_valid/ready - run beat handshake
//   out_value       - run value
//   out_mult        - run length (1..9)
//   out_last        - final run of the vector
//   done            - one-cycle pulse after the final beat is accepted
//   count_err       - sticky: runs emitted != captured unique_count
//   order_err       - sticky: captured vector not non-decreasing
module cussen_run_emitter
    import cussen_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [W-1:0]      in1,
    input  logic [W-1:0]      in2,
    input  logic [W-1:0]      in3,
    input  logic [W-1:0]      in4,
    input  logic [W-1:0]      in5,
    input  logic [W-1:0]      in6,
    input  logic [W-1:0]      in7,
    input  logic [W-1:0]      in8,
    input  logic [W-1:0]      in9,
    input  logic [3:0]        unique_count,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_value,
    output logic [MULT_W-1:0] out_mult,
    output logic              out_last,
    output logic              done,
    output logic              count_err,
    output logic              order_err
);

    state_t              state;
    logic [W-1:0]        buf_q [N_IN];
    logic [IDX_W-1:0]    idx;
    logic [3:0]          emitted;
    logic [3:0]          uc_q;

    logic [MULT_W-1:0]   run_len;
    logic [4:0]          idx_end;
    logic                is_last;
    logic                order_bad;
    logic [IDX_W-1:0]    idx_c;

    cussen_run_len #(.W(W)) u_run_len (
        .vals    (buf_q),
        .idx     (idx),
        .run_len (run_len)
    );

    // Keep the read index in range even when idx sits at 9 outside EMIT.
    assign idx_c   = (idx < IDX_W'(N_IN)) ? idx : '0;
    // 5-bit sum so idx + run length cannot wrap.
    assign idx_end = 5'(idx) + 5'(run_len);
    assign is_last = (idx_end == 5'(N_IN));

    always_comb begin
        order_bad = 1'b0;
        for (int i = 0; i < N_IN - 1; i++) begin
            if (buf_q[i] > buf_q[i+1]) begin
                order_bad = 1'b1;
            end
        end
    end

    // Outputs decode only registered state, so out_ready never reaches
    // out_valid/out_value/out_mult combinationally.
    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign out_value = (state == EMIT) ? buf_q[idx_c] : '0;
    assign out_mult  = (state == EMIT) ? run_len : '0;
    assign out_last  = (state == EMIT) && is_last;
    assign done      = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            emitted   <= '0;
            uc_q      <= '0;
            count_err <= 1'b0;
            order_err <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        buf_q[0]  <= in1;
                        buf_q[1]  <= in2;
                        buf_q[2]  <= in3;
                        buf_q[3]  <= in4;
                        buf_q[4]  <= in5;
                        buf_q[5]  <= in6;
                        buf_q[6]  <= in7;
                        buf_q[7]  <= in8;
                        buf_q[8]  <= in9;
                        uc_q      <= unique_count;
                        idx       <= '0;
                        emitted   <= '0;
                        count_err <= 1'b0;
                        order_err <= 1'b0;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        idx     <= idx_end[IDX_W-1:0];
                        emitted <= (emitted == 4'(N_IN)) ? emitted : emitted + 4'd1;
                        if (is_last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    count_err <= (emitted != uc_q);
                    order_err <= order_bad;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cussen_run_emitter.sv
module tb_cussen_run_emitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] vin [9];
    logic [3:0] ucnt;
    logic       busy, out_valid, out_ready, out_last, done, count_err, order_err;
    logic [7:0] out_value;
    logic [3:0] out_mult;

    int checks = 0;
    int errors = 0;

    logic [7:0] v1   [9] = '{8'd1, 8'd1, 8'd3, 8'd4, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9};
    logic [7:0] v42  [9] = '{8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42};
    logic [7:0] vseq [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    logic [7:0] vuns [9] = '{8'd5, 8'd3, 8'd3, 8'd4, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9};

    int val1 [9] = '{1, 3, 4, 5, 6, 8, 9, 0, 0};
    int mul1 [9] = '{2, 1, 2, 1, 1, 1, 1, 0, 0};
    int val42[9] = '{42, 0, 0, 0, 0, 0, 0, 0, 0};
    int mul42[9] = '{9, 0, 0, 0, 0, 0, 0, 0, 0};
    int valu [9] = '{5, 3, 4, 6, 7, 8, 9, 0, 0};
    int mulu [9] = '{1, 2, 2, 1, 1, 1, 1, 0, 0};

    always #5 clk = ~clk;

    cussen_run_emitter #(.W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .in1          (vin[0]),
        .in2          (vin[1]),
        .in3          (vin[2]),
        .in4          (vin[3]),
        .in5          (vin[4]),
        .in6          (vin[5]),
        .in7          (vin[6]),
        .in8          (vin[7]),
        .in9          (vin[8]),
        .unique_count (ucnt),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_value    (out_value),
        .out_mult     (out_mult),
        .out_last     (out_last),
        .done         (done),
        .count_err    (count_err),
        .order_err    (order_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input int v, input int m, input int last);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " value"}, 32'(out_value), 32'(v));
        chk({tag, " mult"},  32'(out_mult),  32'(m));
        chk({tag, " last"},  32'(out_last),  32'(last));
    endtask

    task automatic do_load(input logic [7:0] v [9], input logic [3:0] uc);
        for (int i = 0; i < 9; i++) vin[i] = v[i];
        ucnt = uc;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("load busy", 32'(busy), 32'd1);
        chk("load valid", 32'(out_valid), 32'd1);
    endtask

    // Ready held high: expects n beats, then a DONE cycle, then IDLE.
    task automatic run_stream(input string tag, input int n, input int vals [9], input int mults [9]);
        for (int i = 0; i < n; i++) begin
            expect_beat(tag, vals[i], mults[i], (i == n - 1) ? 1 : 0);
            tick();
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " done valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"},      32'(busy),      32'd0);
        chk({tag, " valid"},     32'(out_valid), 32'd0);
        chk({tag, " value"},     32'(out_value), 32'd0);
        chk({tag, " mult"},      32'(out_mult),  32'd0);
        chk({tag, " last"},      32'(out_last),  32'd0);
        chk({tag, " done"},      32'(done),      32'd0);
        chk({tag, " count_err"}, 32'(count_err), 32'd0);
        chk({tag, " order_err"}, 32'(order_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        out_ready = 1'b1;
        ucnt = 4'd0;
        for (int i = 0; i < 9; i++) vin[i] = 8'd0;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("post reset idle");

        // Test 1: normal vector, 7 runs
        do_load(v1, 4'd7);
        run_stream("t1", 7, val1, mul1);
        chk("t1 count_err", 32'(count_err), 32'd0);
        chk("t1 order_err", 32'(order_err), 32'd0);

        // Test 2: all equal, single beat of multiplicity 9
        do_load(v42, 4'd1);
        run_stream("t2", 1, val42, mul42);
        chk("t2 count_err", 32'(count_err), 32'd0);
        chk("t2 order_err", 32'(order_err), 32'd0);

        // Test 3: 1..9 with ready pattern 1,0,0,1,0,0,...
        do_load(vseq, 4'd9);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) begin
                out_ready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    expect_beat("t3 stall", k, 1, (k == 9) ? 1 : 0);
                    tick();
                end
            end
            out_ready = 1'b1;
            expect_beat("t3 beat", k, 1, (k == 9) ? 1 : 0);
            tick();
        end
        chk("t3 done", 32'(done), 32'd1);
        tick();
        chk("t3 idle", 32'(busy), 32'd0);
        chk("t3 count_err", 32'(count_err), 32'd0);

        // Test 4a: wrong unique_count
        do_load(v1, 4'd6);
        run_stream("t4a", 7, val1, mul1);
        chk("t4a count_err", 32'(count_err), 32'd1);
        chk("t4a order_err", 32'(order_err), 32'd0);
        tick();
        chk("t4a count_err sticky", 32'(count_err), 32'd1);

        // Test 4b: unsorted vector; load clears count_err
        do_load(vuns, 4'd7);
        chk("t4b count_err cleared", 32'(count_err), 32'd0);
        run_stream("t4b", 7, valu, mulu);
        chk("t4b count_err", 32'(count_err), 32'd0);
        chk("t4b order_err", 32'(order_err), 32'd1);

        // Test 5: load during EMIT ignored; also clears order_err on real load
        do_load(v1, 4'd7);
        chk("t5 order_err cleared", 32'(order_err), 32'd0);
        for (int i = 0; i < 7; i++) begin
            expect_beat("t5", val1[i], mul1[i], (i == 6) ? 1 : 0);
            if (i == 1) begin
                for (int j = 0; j < 9; j++) vin[j] = vseq[j];
                ucnt = 4'd9;
                load = 1'b1;
            end
            tick();
            load = 1'b0;
        end
        chk("t5 done", 32'(done), 32'd1);
        tick();
        chk("t5 idle", 32'(busy), 32'd0);
        chk("t5 count_err", 32'(count_err), 32'd0);
        tick();
        chk("t5 no requeue", 32'(busy), 32'd0);

        // Test 6: async reset mid-stream, then fresh stream
        do_load(v1, 4'd7);
        for (int i = 0; i < 3; i++) begin
            expect_beat("t6 pre", val1[i], mul1[i], 0);
            tick();
        end
        expect_beat("t6 beat4", val1[3], mul1[3], 0);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("t6 async");
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("t6 idle");
        do_load(v1, 4'd7);
        run_stream("t6 fresh", 7, val1, mul1);
        chk("t6 count_err", 32'(count_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
